// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush/drain sequencer: Mealy stall and flush controls, registered status.
// Zero-cycle response to load-use and taken branches; valid low aborts to IDLE on the next edge.
module pipe_hazard_ctrl #(
   parameter int ADDR_LINE_REG = 5,
   parameter int CNT_W         = 16,
   parameter int DRAIN_CYCLES  = 4,
   parameter int FLUSH_CYCLES  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid,
   input  logic                     opr_finished,
   input  logic [ADDR_LINE_REG-1:0] id_rs_addr,
   input  logic [ADDR_LINE_REG-1:0] id_rt_addr,
   input  logic                     id_uses_rt,
   input  logic                     ex_mem_read,
   input  logic [ADDR_LINE_REG-1:0] ex_rd_addr,
   input  logic                     ex_branch_taken,
   output logic                     pipe_en,
   output logic                     hazard,
   output logic                     bubble_ex,
   output logic                     flush_if_id,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_FLUSH = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [FW-1:0]     flush_q, flush_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;
   logic              busy_q, done_q;
   logic              load_use;

   assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                     ((ex_rd_addr == id_rs_addr) || (id_uses_rt && (ex_rd_addr == id_rt_addr)));

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      drain_d     = drain_q;
      flush_d     = flush_q;
      stall_d     = stall_q;
      fcnt_d      = fcnt_q;
      hazard      = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               state_d = S_RUN;
               stall_d = '0;
               fcnt_d  = '0;
               pend_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else if (ex_branch_taken) begin
               // Branch wins over load-use: the stalled instruction is squashed anyway.
               flush_if_id = 1'b1;
               bubble_ex   = 1'b1;
               if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
               pend_d  = pend_q | opr_finished;
               flush_d = FLUSH_LOAD;
               state_d = S_FLUSH;
            end else begin
               if (load_use) begin
                  hazard    = 1'b1;
                  bubble_ex = 1'b1;
               end
               if (opr_finished) begin
                  drain_d = DRAIN_LOAD;
                  state_d = S_DRAIN;
               end
            end
         end
         S_FLUSH: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else begin
               flush_if_id = 1'b1;
               bubble_ex   = 1'b1;
               if (flush_q == '0) begin
                  if (pend_q || opr_finished) begin
                     drain_d = DRAIN_LOAD;
                     pend_d  = 1'b0;
                     state_d = S_DRAIN;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  flush_d = flush_q - 1'b1;
                  pend_d  = pend_q | opr_finished;
               end
            end
         end
         S_DRAIN: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else begin
               flush_if_id = 1'b1;
               // A stall freezes the drain count: the stalled slot did not advance the pipe.
               if (load_use) begin
                  hazard    = 1'b1;
                  bubble_ex = 1'b1;
               end else if (drain_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
         end
         S_DONE: begin
            if (!valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pend_q  <= 1'b0;
         drain_q <= '0;
         flush_q <= '0;
         stall_q <= '0;
         fcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         drain_q <= drain_d;
         flush_q <= flush_d;
         stall_q <= stall_d;
         fcnt_q  <= fcnt_d;
         busy_q  <= (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign pipe_en   = busy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = fcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed stimulus for pipe_hazard_ctrl, checked against a cycle-level reference
// model through an expectation queue drained by an independent monitor.
module tb_pipe_hazard_ctrl;

   localparam int DRAIN_CYCLES = 4;
   localparam int FLUSH_CYCLES = 1;
   localparam int SAT = 65535;

   localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3, M_DONE = 4;

   logic        clk = 1'b0;
   logic        reset, valid, opr_finished, id_uses_rt, ex_mem_read, ex_branch_taken;
   logic [4:0]  id_rs_addr, id_rt_addr, ex_rd_addr;
   logic        pipe_en, hazard, bubble_ex, flush_if_id, busy, done;
   logic [15:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(
      .ADDR_LINE_REG(5), .CNT_W(16), .DRAIN_CYCLES(DRAIN_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_branch_taken(ex_branch_taken),
      .pipe_en(pipe_en), .hazard(hazard), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
      .busy(busy), .done(done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [37:0] exp_q[$];

   int mode = M_IDLE;
   int flush_left = 0, drain_left = 0, sc = 0, fc = 0;
   bit pend = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [37:0] dut_vec();
      return {pipe_en, hazard, bubble_ex, flush_if_id, busy, done, stall_cnt, flush_cnt};
   endfunction

   // One clock of stimulus: drive, predict this cycle's outputs, then advance the model.
   task automatic cyc(input bit v, input bit of, input int rs, input int rt, input bit urt,
                      input bit mr, input int rd, input bit br);
      bit lu, act, bsy, hz, bb, fl;
      @(posedge clk); #1;
      valid = v; opr_finished = of; id_rs_addr = 5'(rs); id_rt_addr = 5'(rt);
      id_uses_rt = urt; ex_mem_read = mr; ex_rd_addr = 5'(rd); ex_branch_taken = br;
      lu  = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
      bsy = (mode == M_RUN) || (mode == M_FLUSH) || (mode == M_DRAIN);
      act = bsy && v;
      hz  = act && (((mode == M_RUN) && !br && lu) || ((mode == M_DRAIN) && lu));
      bb  = act && (((mode == M_RUN) && (br || lu)) || (mode == M_FLUSH) || ((mode == M_DRAIN) && lu));
      fl  = act && (((mode == M_RUN) && br) || (mode == M_FLUSH) || (mode == M_DRAIN));
      exp_q.push_back({bsy, hz, bb, fl, bsy, (mode == M_DONE), 16'(sc), 16'(fc)});
      if (hz && sc < SAT) sc++;
      if (mode == M_IDLE) begin
         if (v) begin mode = M_RUN; sc = 0; fc = 0; pend = 0; end
      end else if (bsy && !v) begin
         mode = M_IDLE;
      end else if (mode == M_RUN) begin
         if (br) begin
            if (fc < SAT) fc++;
            pend = of; flush_left = FLUSH_CYCLES; mode = M_FLUSH;
         end else if (of) begin
            mode = M_DRAIN; drain_left = DRAIN_CYCLES;
         end
      end else if (mode == M_FLUSH) begin
         pend = pend | of;
         flush_left--;
         if (flush_left == 0) begin
            if (pend) begin mode = M_DRAIN; drain_left = DRAIN_CYCLES; pend = 0; end
            else mode = M_RUN;
         end
      end else if (mode == M_DRAIN) begin
         if (!lu) begin
            drain_left--;
            if (drain_left == 0) mode = M_DONE;
         end
      end else if (mode == M_DONE) begin
         if (!v) mode = M_IDLE;
      end
   endtask

   task automatic plain(input bit v);
      cyc(v, 0, 1, 2, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      chk("reset_async", dut_vec(), 38'h0);
      mode = M_IDLE; sc = 0; fc = 0; pend = 0; flush_left = 0; drain_left = 0;
      valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      valid = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) chk("cycle", dut_vec(), exp_q.pop_front());
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; valid = 0; opr_finished = 0; id_rs_addr = 0; id_rt_addr = 0;
      id_uses_rt = 0; ex_mem_read = 0; ex_rd_addr = 0; ex_branch_taken = 0;
      #1;
      chk("reset_state", dut_vec(), 38'h0);
      #11 reset = 1'b1;

      // Load-use on rs, then the r0 exemption.
      plain(1);
      cyc(1, 0, 5, 9, 0, 1, 5, 0); #1;
      chk("lu_hazard_bubble", {hazard, bubble_ex}, 2'b11);
      chk("lu_stall_before", stall_cnt, 0);
      plain(1); #1;
      chk("lu_stall_after", stall_cnt, 1);
      cyc(1, 0, 0, 0, 1, 1, 0, 0); #1;
      chk("r0_no_hazard", hazard, 0);
      plain(1); #1;
      chk("r0_stall_hold", stall_cnt, 1);

      // Branch coincident with load-use.
      cyc(1, 0, 5, 9, 0, 1, 5, 1); #1;
      chk("br_priority", {flush_if_id, bubble_ex, hazard}, 3'b110);
      plain(1); #1;
      chk("flush_cycle", {flush_if_id, flush_cnt}, {1'b1, 16'd1});
      plain(1); #1;
      chk("back_to_run", {flush_if_id, busy}, 2'b01);

      // Finish together with a branch: one flush cycle then four drain cycles.
      cyc(1, 1, 1, 2, 0, 0, 0, 1); #1;
      chk("fin_br_flush", flush_if_id, 1);
      plain(1); #1;
      chk("fin_flush_state", {flush_if_id, done}, 2'b10);
      for (int i = 0; i < DRAIN_CYCLES; i++) begin
         plain(1); #1;
         chk("drain_cycle", {flush_if_id, done, busy}, 3'b101);
      end
      plain(1); #1;
      chk("done_reached", {done, busy, flush_if_id}, 3'b100);

      // Restart; drain with one stall cycle takes five cycles.
      plain(0);
      plain(0); #1;
      chk("idle_after_done", busy, 0);
      plain(1);
      cyc(1, 1, 1, 2, 0, 0, 0, 0); #1;
      chk("cnt_cleared", {stall_cnt, flush_cnt}, 32'h0);
      cyc(1, 0, 3, 2, 0, 1, 3, 0); #1;
      chk("drain_stall", {hazard, flush_if_id}, 2'b11);
      for (int i = 0; i < DRAIN_CYCLES; i++) begin
         plain(1); #1;
         chk("drain_not_done", done, 0);
      end
      plain(1); #1;
      chk("drain_stall_done", {done, stall_cnt}, {1'b1, 16'd1});

      // Saturate stall_cnt.
      plain(0);
      plain(0);
      plain(1);
      for (int i = 0; i < SAT + 5; i++) cyc(1, 0, 7, 0, 0, 1, 7, 0);
      #1;
      chk("stall_sat", stall_cnt, 16'hFFFF);
      cyc(1, 0, 4, 4, 1, 1, 4, 0);
      plain(1); #1;
      chk("stall_sat_hold", stall_cnt, 16'hFFFF);

      // Reset while in FLUSH.
      cyc(1, 0, 1, 2, 0, 0, 0, 1);
      plain(1); #1;
      chk("pre_reset_flush", flush_if_id, 1);
      do_reset();
      plain(0);
      plain(0); #1;
      chk("idle_after_reset", {busy, stall_cnt}, 17'h0);

      for (int i = 0; i < 3000; i++) begin
         bit v;
         v = (mode == M_DONE) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 99) < 97);
         cyc(v, $urandom_range(0, 99) < 6, $urandom_range(0, 3), $urandom_range(0, 3),
             bit'($urandom_range(0, 1)), $urandom_range(0, 99) < 40, $urandom_range(0, 3),
             $urandom_range(0, 99) < 10);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
